// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the register file, shared by pipeline WB (A) and the multi-cycle unit (B).
// It also holds the pending-write scoreboard. Optional B anti-starvation: define RF_ARB_STARVE_EN.
module rf_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              claim_err,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd
);

  localparam int NREG = 1 << ADDR_W;

  logic            force_b;
  logic            a_xfer;
  logic            b_xfer;
  logic            a_wr;
  logic            b_wr;
  logic            claim_set;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

`ifdef RF_ARB_STARVE_EN
  // B starvation timer: a down-counter loaded with the limit, and B is forced at terminal count.
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_LOAD = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_left;

  assign force_b = (starve_left == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_left <= STARVE_LOAD;
    end else if (!b_valid || b_xfer) begin
      starve_left <= STARVE_LOAD;
    end else if (!force_b) begin
      starve_left <= starve_left - 1'b1;
    end
  end
`else
  assign force_b = 1'b0;
`endif

  assign a_ready = rst_n && !force_b;
  assign b_ready = rst_n && (!a_valid || force_b);

  assign a_xfer    = a_valid && a_ready;
  assign b_xfer    = b_valid && b_ready && !a_xfer;
  assign a_wr      = a_xfer && (a_addr != '0);
  assign b_wr      = b_xfer && (b_addr != '0);
  assign claim_set = claim_en && (claim_addr != '0);

  // A write to r0 is accepted but leaves the write port (including wa/wd) untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= a_wr || b_wr;
      if (a_wr) begin
        rf_wa <= a_addr;
        rf_wd <= a_data;
      end else if (b_wr) begin
        rf_wa <= b_addr;
        rf_wd <= b_data;
      end
    end
  end

  // When a claim and a B clear hit the same register in one cycle, the claim is applied last.
  always_comb begin
    pending_nxt = pending;
    if (b_wr) begin
      pending_nxt[b_addr] = 1'b0;
    end
    if (claim_set) begin
      pending_nxt[claim_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      claim_err <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (claim_set && pending[claim_addr]) begin
        claim_err <= 1'b1;
      end
    end
  end

  assign chk_busy1 = (chk_addr1 != '0) && pending[chk_addr1];
  assign chk_busy2 = (chk_addr2 != '0) && pending[chk_addr2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized self-checking bench for rf_wb_arbiter. A behavioural model is compared on every
// negedge, and directed sequences pin literal values.
module tb_rf_wb_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LIM = 4;
`ifdef RF_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0, claim_en = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0, claim_addr = '0, chk_addr1 = '0, chk_addr2 = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, chk_busy1, chk_busy2, claim_err, rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2), .claim_err(claim_err),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Regfile stand-in: commits on the negedge following the write-port update.
  logic [DW-1:0] rf_mem [32];
  always @(negedge clk) if (rf_we === 1'b1) rf_mem[rf_wa] <= rf_wd;

  // Behavioural model: wait counter, pending set, sticky error and last write.
  bit        started = 1'b0;
  bit [31:0] m_pend  = '0;
  int        m_cnt   = 0;
  bit        m_err   = 1'b0;
  bit        m_we    = 1'b0;
  bit [4:0]  m_wa    = '0;
  bit [31:0] m_wd    = '0;

  function automatic bit m_force();
    return STARVE_ON && (m_cnt >= LIM);
  endfunction

  always @(posedge clk) begin : model
    bit fb, ax, bx;
    started = 1'b1;
    if (!rst_n) begin
      m_pend = '0; m_cnt = 0; m_err = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      fb = m_force();
      ax = a_valid && !fb;
      bx = b_valid && !ax && (!a_valid || fb);
      m_we = (ax && a_addr != 0) || (bx && b_addr != 0);
      if (ax && a_addr != 0) begin
        m_wa = a_addr; m_wd = a_data;
      end else if (bx && b_addr != 0) begin
        m_wa = b_addr; m_wd = b_data;
      end
      if (claim_en && claim_addr != 0 && m_pend[claim_addr]) m_err = 1'b1;
      if (bx && b_addr != 0) m_pend[b_addr] = 1'b0;
      if (claim_en && claim_addr != 0) m_pend[claim_addr] = 1'b1;
      if (!b_valid || bx) m_cnt = 0;
      else if (m_cnt < LIM) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin : compare
    bit fb;
    if (started) begin
      fb = m_force();
      chk("a_ready",   a_ready,   rst_n && !fb);
      chk("b_ready",   b_ready,   rst_n && (!a_valid || fb));
      chk("chk_busy1", chk_busy1, (chk_addr1 != 0) && m_pend[chk_addr1]);
      chk("chk_busy2", chk_busy2, (chk_addr2 != 0) && m_pend[chk_addr2]);
      chk("claim_err", claim_err, m_err);
      chk("rf_we",     rf_we,     m_we);
      chk("rf_wa",     rf_wa,     m_wa);
      chk("rf_wd",     rf_wd,     m_wd);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    // 1: reset, then a single A write to r5
    step();
    settle();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    step();
    rst_n = 1'b1;
    a_valid = 1'b1; a_addr = 5; a_data = 32'hDEAD_BEEF;
    settle();
    chk("t1_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    settle();
    chk("t1_rf_we", rf_we, 1);
    chk("t1_rf_wa", rf_wa, 5);
    chk("t1_rf_wd", rf_wd, 32'hDEAD_BEEF);
    chk("t1_regfile_r5", rf_mem[5], 32'hDEAD_BEEF);

    // 2: A and B contend; with the starve feature, B is forced on the fifth cycle
    step();
    a_valid = 1'b1; a_addr = 3; a_data = 32'h33;
    b_valid = 1'b1; b_addr = 9; b_data = 32'h99;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t2_a_ready", a_ready, !(STARVE_ON && k == 4));
      chk("t2_b_ready", b_ready, STARVE_ON && k == 4);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    settle();
    chk("t2_rf_wa", rf_wa, STARVE_ON ? 9 : 3);
    chk("t2_rf_wd", rf_wd, STARVE_ON ? 32'h99 : 32'h33);
    chk("t2_a_ready_after", a_ready, 1);

    // 3: claim r12, observe busy next cycle, clear it with a B write
    step();
    claim_en = 1'b1; claim_addr = 12; chk_addr1 = 12;
    settle();
    chk("t3_busy_same_cycle", chk_busy1, 0);
    step();
    claim_en = 1'b0;
    settle();
    chk("t3_busy_set", chk_busy1, 1);
    step();
    b_valid = 1'b1; b_addr = 12; b_data = 7;
    settle();
    chk("t3_b_ready", b_ready, 1);
    step();
    b_valid = 1'b0;
    settle();
    chk("t3_busy_clear", chk_busy1, 0);
    chk("t3_rf_we", rf_we, 1);
    chk("t3_rf_wd", rf_wd, 7);

    // 4: same-cycle claim and clear of r12 leaves it pending; a re-claim sets the sticky error
    step();
    claim_en = 1'b1; claim_addr = 12;
    b_valid = 1'b1; b_addr = 12; b_data = 8;
    step();
    claim_en = 1'b0; b_valid = 1'b0;
    settle();
    chk("t4_busy_set_wins", chk_busy1, 1);
    chk("t4_no_err_yet", claim_err, 0);
    step();
    claim_en = 1'b1; claim_addr = 12;
    step();
    claim_en = 1'b0;
    settle();
    chk("t4_claim_err", claim_err, 1);
    repeat (3) step();
    settle();
    chk("t4_claim_err_sticky", claim_err, 1);

    // 5: a write to r0 is accepted but never reaches the regfile
    step();
    a_valid = 1'b1; a_addr = 0; a_data = 32'hFFFF_FFFF;
    settle();
    chk("t5_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0; chk_addr1 = 0;
    settle();
    chk("t5_rf_we", rf_we, 0);
    chk("t5_busy_r0", chk_busy1, 0);

    // 6: reset mid-stream with r12 pending and a write in flight
    step();
    a_valid = 1'b1; a_addr = 4; a_data = 32'h44; chk_addr2 = 12;
    step();
    settle();
    chk("t6_rf_we_before", rf_we, 1);
    chk("t6_busy_before", chk_busy2, 1);
    rst_n = 1'b0; b_valid = 1'b1;
    #1;
    chk("t6_a_ready_rst", a_ready, 0);
    chk("t6_b_ready_rst", b_ready, 0);
    step();
    settle();
    chk("t6_rf_we", rf_we, 0);
    chk("t6_rf_wa", rf_wa, 0);
    chk("t6_rf_wd", rf_wd, 0);
    chk("t6_busy", chk_busy2, 0);
    chk("t6_claim_err", claim_err, 0);
    step();
    rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;

    // Randomized traffic with small address range to force collisions
    for (int i = 0; i < 3000; i++) begin
      step();
      rst_n      = ($urandom_range(0, 199) != 0);
      a_valid    = ($urandom_range(0, 99) < 60);
      b_valid    = ($urandom_range(0, 99) < 55);
      a_addr     = AW'($urandom_range(0, 7));
      b_addr     = AW'($urandom_range(0, 15));
      a_data     = $urandom;
      b_data     = $urandom;
      claim_en   = ($urandom_range(0, 99) < 25);
      claim_addr = AW'($urandom_range(0, 15));
      chk_addr1  = AW'($urandom_range(0, 15));
      chk_addr2  = AW'($urandom_range(0, 31));
    end
    step();
    a_valid = 1'b0; b_valid = 1'b0; claim_en = 1'b0;
    settle();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
